// File: rtl/rtc_bus_arbiter.sv
// Arbiter and bus sequencer for the external RTC's multiplexed address/data bus.
// Shares the bus between the edit/write path and the display read sweep.
module rtc_bus_arbiter #(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_STROBE  = 8,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_RECOVER = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       ChipSelect,
  output logic       Read,
  output logic       Write,
  output logic       AoD
);

  localparam logic [7:0] CntSetup   = 8'(T_SETUP);
  localparam logic [7:0] CntStrobe  = 8'(T_STROBE);
  localparam logic [7:0] CntHold    = 8'(T_HOLD);
  localparam logic [7:0] CntRecover = 8'(T_RECOVER);

  typedef enum logic [2:0] {
    StIdle, StASetup, StAStrobe, StAHold, StDSetup, StDStrobe, StDHold, StRecover
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       last_wr_q, last_wr_d;

  logic       cs_q, cs_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       aod_q, aod_d;
  logic       oe_q, oe_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       wr_ack_q, wr_ack_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q;
  logic       addr_ph, data_ph, done, capture;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    last_wr_d = last_wr_q;
    if (state_q == StIdle) begin
      // On contention the requester that was not served last wins.
      if (wr_req && (!rd_req || !last_wr_q)) begin
        state_d   = StASetup;
        cnt_d     = CntSetup;
        is_wr_d   = 1'b1;
        addr_d    = wr_addr;
        data_d    = wr_data;
        last_wr_d = 1'b1;
      end else if (rd_req) begin
        state_d   = StASetup;
        cnt_d     = CntSetup;
        is_wr_d   = 1'b0;
        addr_d    = rd_addr;
        data_d    = 8'h00;
        last_wr_d = 1'b0;
      end
    end else if (cnt_q == 8'd1) begin
      unique case (state_q)
        StASetup:  begin state_d = StAStrobe; cnt_d = CntStrobe;  end
        StAStrobe: begin state_d = StAHold;   cnt_d = CntHold;    end
        StAHold:   begin state_d = StDSetup;  cnt_d = CntSetup;   end
        StDSetup:  begin state_d = StDStrobe; cnt_d = CntStrobe;  end
        StDStrobe: begin state_d = StDHold;   cnt_d = CntHold;    end
        StDHold:   begin state_d = StRecover; cnt_d = CntRecover; end
        default:   begin state_d = StIdle;    cnt_d = 8'd0;       end
      endcase
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Pin values are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    addr_ph    = (state_d == StASetup) || (state_d == StAStrobe) || (state_d == StAHold);
    data_ph    = (state_d == StDSetup) || (state_d == StDStrobe) || (state_d == StDHold);
    cs_d       = !((state_d == StAStrobe) || (state_d == StDStrobe));
    wr_n_d     = !((state_d == StAStrobe) || ((state_d == StDStrobe) && is_wr_d));
    rd_n_d     = !((state_d == StDStrobe) && !is_wr_d);
    aod_d      = !addr_ph;
    oe_d       = addr_ph || (data_ph && is_wr_d);
    bus_out_d  = addr_ph ? addr_d : ((data_ph && is_wr_d) ? data_d : 8'h00);
    done       = (state_q == StRecover) && (cnt_q == 8'd1);
    wr_ack_d   = done && is_wr_q;
    rd_valid_d = done && !is_wr_q;
    capture    = (state_q == StDStrobe) && (cnt_q == 8'd1) && !is_wr_q;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      is_wr_q    <= 1'b0;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      last_wr_q  <= 1'b0;
      cs_q       <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      aod_q      <= 1'b1;
      oe_q       <= 1'b0;
      bus_out_q  <= 8'h00;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      last_wr_q  <= last_wr_d;
      cs_q       <= cs_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      aod_q      <= aod_d;
      oe_q       <= oe_d;
      bus_out_q  <= bus_out_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      if (capture) rd_data_q <= bus_in;
    end
  end

  assign busy       = (state_q != StIdle);
  assign ChipSelect = cs_q;
  assign Read       = rd_n_q;
  assign Write      = wr_n_q;
  assign AoD        = aod_q;
  assign bus_oe     = oe_q;
  assign bus_out    = bus_out_q;
  assign wr_ack     = wr_ack_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: default-timing instance plus a fast-timing instance.
module tb_rtc_bus_arbiter;

  logic       clk = 1'b0;
  logic       Reset;
  logic       wr_req, rd_req;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic       wr_ack, rd_valid, busy, bus_oe;
  logic [7:0] rd_data, bus_out, bus_in;
  logic       ChipSelect, Read, Write, AoD;

  logic       p_rd_req;
  logic [7:0] p_rd_addr;
  logic       p_wr_ack, p_rd_valid, p_busy, p_bus_oe;
  logic [7:0] p_rd_data, p_bus_out, p_bus_in;
  logic       p_cs, p_read, p_write, p_aod;

  int checks = 0;
  int errors = 0;

  logic       cs_a[1:40], rd_a[1:40], wr_a[1:40], aod_a[1:40], oe_a[1:40];
  logic       ack_a[1:40], rv_a[1:40], busy_a[1:40];
  logic [7:0] bo_a[1:40], rdd_a[1:40];
  logic       pcs_a[1:40], prd_a[1:40], prv_a[1:40];
  logic [7:0] prdd_a[1:40];

  always #5 clk = ~clk;

  // The RTC model drives its register value only while Read is low.
  assign bus_in   = (Read == 1'b0) ? 8'h35 : 8'hc3;
  assign p_bus_in = (p_read == 1'b0) ? 8'h5a : 8'h00;

  rtc_bus_arbiter dut (
    .clk(clk), .Reset(Reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .ChipSelect(ChipSelect), .Read(Read), .Write(Write), .AoD(AoD)
  );

  rtc_bus_arbiter #(.T_SETUP(1), .T_STROBE(3), .T_HOLD(1), .T_RECOVER(1)) dut_p (
    .clk(clk), .Reset(Reset),
    .wr_req(1'b0), .wr_addr(8'h00), .wr_data(8'h00), .wr_ack(p_wr_ack),
    .rd_req(p_rd_req), .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_valid(p_rd_valid),
    .busy(p_busy), .bus_out(p_bus_out), .bus_oe(p_bus_oe), .bus_in(p_bus_in),
    .ChipSelect(p_cs), .Read(p_read), .Write(p_write), .AoD(p_aod)
  );

  // Sample k is taken on the falling edge after the k-th rising edge from now.
  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cs_a[k] = ChipSelect; rd_a[k] = Read; wr_a[k] = Write; aod_a[k] = AoD;
      oe_a[k] = bus_oe; bo_a[k] = bus_out; ack_a[k] = wr_ack; rv_a[k] = rd_valid;
      rdd_a[k] = rd_data; busy_a[k] = busy;
      pcs_a[k] = p_cs; prd_a[k] = p_read; prv_a[k] = p_rd_valid; prdd_a[k] = p_rd_data;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; p_rd_req = 1'b0;
    wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00; p_rd_addr = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({ChipSelect, Read, Write, AoD} !== 4'b1111) begin
      errors++; $display("FAIL reset_strobes: got %b want 1111", {ChipSelect, Read, Write, AoD});
    end
    checks++;
    if ({bus_oe, bus_out} !== 9'h000) begin
      errors++; $display("FAIL reset_bus: got oe=%b out=%h want 0/00", bus_oe, bus_out);
    end
    checks++;
    if ({wr_ack, rd_valid, busy, rd_data} !== 11'h000) begin
      errors++;
      $display("FAIL reset_status: got ack=%b rv=%b busy=%b rdd=%h want 0/0/0/00",
               wr_ack, rd_valid, busy, rd_data);
    end
    Reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    int nwr, nrd, ncs, nack;
    wr_addr = 8'h21; wr_data = 8'h45; wr_req = 1'b1;
    capture(29);
    wr_req = 1'b0;
    wr_addr = 8'hee; wr_data = 8'hee;
    nwr = 0; nrd = 0; ncs = 0; nack = 0;
    for (int k = 1; k <= 29; k++) begin
      if (wr_a[k] == 1'b0) nwr++;
      if (rd_a[k] == 1'b0) nrd++;
      if (cs_a[k] == 1'b0) ncs++;
      if (ack_a[k] == 1'b1) nack++;
    end
    checks++;
    if ({aod_a[1], oe_a[1], bo_a[1], cs_a[1], busy_a[1]} !== {2'b01, 8'h21, 2'b11}) begin
      errors++;
      $display("FAIL wr_addr_setup: got aod=%b oe=%b out=%h cs=%b busy=%b want 0/1/21/1/1",
               aod_a[1], oe_a[1], bo_a[1], cs_a[1], busy_a[1]);
    end
    checks++;
    if (cs_a[2] !== 1'b1) begin errors++; $display("FAIL wr_setup_len: got cs=%b want 1", cs_a[2]); end
    checks++;
    if ({cs_a[3], wr_a[3], aod_a[3], bo_a[3]} !== {3'b000, 8'h21}) begin
      errors++;
      $display("FAIL wr_astrobe_start: got cs=%b w=%b aod=%b out=%h want 0/0/0/21",
               cs_a[3], wr_a[3], aod_a[3], bo_a[3]);
    end
    checks++;
    if ({cs_a[10], wr_a[10], cs_a[11], wr_a[11], aod_a[11]} !== 5'b00110) begin
      errors++;
      $display("FAIL wr_astrobe_end: got %b want 00110",
               {cs_a[10], wr_a[10], cs_a[11], wr_a[11], aod_a[11]});
    end
    checks++;
    if ({aod_a[13], oe_a[13], bo_a[13], cs_a[13]} !== {2'b11, 8'h45, 1'b1}) begin
      errors++;
      $display("FAIL wr_data_setup: got aod=%b oe=%b out=%h cs=%b want 1/1/45/1",
               aod_a[13], oe_a[13], bo_a[13], cs_a[13]);
    end
    checks++;
    if ({cs_a[15], wr_a[15], wr_a[22], wr_a[23], bo_a[22]} !== {4'b0001, 8'h45}) begin
      errors++;
      $display("FAIL wr_dstrobe: got %b out=%h want 0001/45",
               {cs_a[15], wr_a[15], wr_a[22], wr_a[23]}, bo_a[22]);
    end
    checks++;
    if ({nwr, ncs, nrd} !== {32'd16, 32'd16, 32'd0}) begin
      errors++;
      $display("FAIL wr_strobe_counts: got w=%0d cs=%0d r=%0d want 16/16/0", nwr, ncs, nrd);
    end
    checks++;
    if ({oe_a[25], aod_a[25], busy_a[28]} !== 3'b011) begin
      errors++; $display("FAIL wr_recover: got oe=%b aod=%b busy=%b want 0/1/1",
                         oe_a[25], aod_a[25], busy_a[28]);
    end
    checks++;
    if ({nack, ack_a[29], busy_a[29]} !== {32'd1, 2'b10}) begin
      errors++;
      $display("FAIL wr_ack_timing: got n=%0d ack29=%b busy29=%b want 1/1/0",
               nack, ack_a[29], busy_a[29]);
    end
    @(negedge clk);
    checks++;
    if ({wr_ack, busy} !== 2'b00) begin
      errors++; $display("FAIL wr_ack_pulse: got ack=%b busy=%b want 0/0", wr_ack, busy);
    end
  endtask

  task automatic test_single_read;
    int nwr, nrd, nrv;
    rd_addr = 8'h22; rd_req = 1'b1;
    capture(29);
    rd_req = 1'b0;
    nwr = 0; nrd = 0; nrv = 0;
    for (int k = 1; k <= 29; k++) begin
      if (wr_a[k] == 1'b0) nwr++;
      if (rd_a[k] == 1'b0) nrd++;
      if (rv_a[k] == 1'b1) nrv++;
    end
    checks++;
    if ({aod_a[1], oe_a[1], bo_a[1], wr_a[3], cs_a[3]} !== {2'b01, 8'h22, 2'b00}) begin
      errors++;
      $display("FAIL rd_addr_phase: got aod=%b oe=%b out=%h w=%b cs=%b want 0/1/22/0/0",
               aod_a[1], oe_a[1], bo_a[1], wr_a[3], cs_a[3]);
    end
    checks++;
    if ({oe_a[13], oe_a[15], oe_a[23], rd_a[15], cs_a[15], wr_a[15]} !== 6'b000001) begin
      errors++;
      $display("FAIL rd_data_phase: got %b want 000001",
               {oe_a[13], oe_a[15], oe_a[23], rd_a[15], cs_a[15], wr_a[15]});
    end
    checks++;
    if ({nwr, nrd, nrv} !== {32'd8, 32'd8, 32'd1}) begin
      errors++; $display("FAIL rd_counts: got w=%0d r=%0d rv=%0d want 8/8/1", nwr, nrd, nrv);
    end
    checks++;
    if ({rdd_a[22], rdd_a[23]} !== 16'h0035) begin
      errors++; $display("FAIL rd_capture_edge: got %h/%h want 00/35", rdd_a[22], rdd_a[23]);
    end
    checks++;
    if ({rv_a[28], rv_a[29], rdd_a[29]} !== {2'b01, 8'h35}) begin
      errors++; $display("FAIL rd_valid_timing: got rv28=%b rv29=%b rdd=%h want 0/1/35",
                         rv_a[28], rv_a[29], rdd_a[29]);
    end
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_data} !== {1'b0, 8'h35}) begin
      errors++; $display("FAIL rd_hold: got rv=%b rdd=%h want 0/35", rd_valid, rd_data);
    end
  endtask

  task automatic test_back_to_back;
    wr_addr = 8'h40; wr_data = 8'h01; wr_req = 1'b1;
    capture(29);
    checks++;
    if ({busy_a[28], busy_a[29], ack_a[29]} !== 3'b101) begin
      errors++; $display("FAIL b2b_first: got %b want 101", {busy_a[28], busy_a[29], ack_a[29]});
    end
    wr_data = 8'h02;
    capture(29);
    wr_req = 1'b0;
    checks++;
    if ({busy_a[1], ack_a[1], aod_a[1], bo_a[1]} !== {3'b100, 8'h40}) begin
      errors++; $display("FAIL b2b_restart: got busy=%b ack=%b aod=%b out=%h want 1/0/0/40",
                         busy_a[1], ack_a[1], aod_a[1], bo_a[1]);
    end
    checks++;
    if ({bo_a[13], ack_a[28], ack_a[29]} !== {8'h02, 2'b01}) begin
      errors++; $display("FAIL b2b_second: got out=%h ack=%b%b want 02/01",
                         bo_a[13], ack_a[28], ack_a[29]);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous;
    Reset = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    wr_addr = 8'h30; wr_data = 8'h77; rd_addr = 8'h31;
    wr_req = 1'b1; rd_req = 1'b1;
    capture(29);
    checks++;
    if ({bo_a[1], ack_a[29], rv_a[29]} !== {8'h30, 2'b10}) begin
      errors++; $display("FAIL sim_first_write: got out=%h ack=%b rv=%b want 30/1/0",
                         bo_a[1], ack_a[29], rv_a[29]);
    end
    capture(29);
    checks++;
    if ({bo_a[1], oe_a[13], ack_a[29], rv_a[29]} !== {8'h31, 3'b001}) begin
      errors++; $display("FAIL sim_then_read: got out=%h oe=%b ack=%b rv=%b want 31/0/0/1",
                         bo_a[1], oe_a[13], ack_a[29], rv_a[29]);
    end
    capture(29);
    wr_req = 1'b0; rd_req = 1'b0;
    checks++;
    if ({bo_a[1], bo_a[13], ack_a[29], rv_a[29]} !== {8'h30, 8'h77, 2'b10}) begin
      errors++; $display("FAIL sim_write_again: got out=%h/%h ack=%b rv=%b want 30/77/1/0",
                         bo_a[1], bo_a[13], ack_a[29], rv_a[29]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int nack;
    wr_addr = 8'h50; wr_data = 8'h66; wr_req = 1'b1;
    capture(16);
    checks++;
    if ({cs_a[16], wr_a[16], oe_a[16]} !== 3'b001) begin
      errors++; $display("FAIL rst_mid_precond: got %b want 001", {cs_a[16], wr_a[16], oe_a[16]});
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({ChipSelect, Write, Read, AoD, bus_oe, busy} !== 6'b111100) begin
      errors++; $display("FAIL rst_mid_async: got %b want 111100",
                         {ChipSelect, Write, Read, AoD, bus_oe, busy});
    end
    nack = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (wr_ack) nack++;
    end
    Reset = 1'b1;
    capture(29);
    wr_req = 1'b0;
    for (int k = 1; k <= 29; k++) if (ack_a[k]) nack++;
    checks++;
    if ({nack, aod_a[1], busy_a[1], ack_a[29]} !== {32'd1, 3'b011}) begin
      errors++; $display("FAIL rst_mid_restart: got n=%0d aod=%b busy=%b ack29=%b want 1/0/1/1",
                         nack, aod_a[1], busy_a[1], ack_a[29]);
    end
    @(negedge clk);
  endtask

  task automatic test_params;
    int nrd, ncs;
    p_rd_addr = 8'h44; p_rd_req = 1'b1;
    capture(12);
    p_rd_req = 1'b0;
    nrd = 0; ncs = 0;
    for (int k = 1; k <= 12; k++) begin
      if (prd_a[k] == 1'b0) nrd++;
      if (pcs_a[k] == 1'b0) ncs++;
    end
    checks++;
    if ({nrd, ncs} !== {32'd3, 32'd6}) begin
      errors++; $display("FAIL par_strobe_width: got r=%0d cs=%0d want 3/6", nrd, ncs);
    end
    checks++;
    if ({pcs_a[1], pcs_a[2], pcs_a[4], pcs_a[5], prd_a[6], prd_a[7], prd_a[9], prd_a[10]}
        !== 8'b10011001) begin
      errors++; $display("FAIL par_strobe_pos: got %b want 10011001",
                         {pcs_a[1], pcs_a[2], pcs_a[4], pcs_a[5],
                          prd_a[6], prd_a[7], prd_a[9], prd_a[10]});
    end
    checks++;
    if ({prv_a[11], prv_a[12], prdd_a[12]} !== {2'b01, 8'h5a}) begin
      errors++; $display("FAIL par_latency: got rv11=%b rv12=%b rdd=%h want 0/1/5a",
                         prv_a[11], prv_a[12], prdd_a[12]);
    end
    @(negedge clk);
    checks++;
    if ({p_rd_valid, p_busy} !== 2'b00) begin
      errors++; $display("FAIL par_idle: got rv=%b busy=%b want 0/0", p_rd_valid, p_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
